// File: rtl/time_set_controller.sv
// Time-set sequencer for the binary LED clock: button sync/debounce, RUN/SET FSM,
// increment pulses, 1 Hz tick gating and inactivity timeout. Define AUTO_REPEAT_EN for held-inc repeat.
`timescale 1ns/1ps
module time_set_controller #(
  parameter int DEBOUNCE_TICKS = 64,
  parameter int TIMEOUT_SECS   = 10,
  parameter int REPEAT_DELAY   = 512,
  parameter int REPEAT_PERIOD  = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       tick_1hz,
  output logic [1:0] mode,
  output logic       run_tick,
  output logic       inc_hour,
  output logic       inc_min,
  output logic       inc_sec
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HRS = 2'b01,
    SET_MIN = 2'b10,
    SET_SEC = 2'b11
  } mode_e;

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TO_W = $clog2(TIMEOUT_SECS + 1);

  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_bad_repeat
    $error("REPEAT_PERIOD must lie in 1..REPEAT_DELAY");
  end

  // Index 0 is the mode button, index 1 the increment button.
  logic [1:0]      raw_btn;
  logic [1:0]      sync1_q, sync2_q, deb_q, deb_prev_q, press_q;
  logic [DB_W-1:0] db_cnt_q [2];

  assign raw_btn = {inc_btn, mode_btn};

  // NOTE: sequential state uses <= so every register samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      press_q    <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q    <= raw_btn;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q;
      for (int b = 0; b < 2; b++) begin
        if (sync2_q[b] != deb_q[b]) begin
          if (db_cnt_q[b] == DB_W'(DEBOUNCE_TICKS - 1)) begin
            deb_q[b]    <= sync2_q[b];
            db_cnt_q[b] <= '0;
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
      end
    end
  end

  mode_e           mode_q;
  logic [2:0]      inc_q;      // {sec, min, hour}
  logic [TO_W-1:0] to_cnt_q;
  logic [2:0]      sel_pulse;
  logic            in_set, timeout, mode_press, inc_press;

  assign mode_press = press_q[0];
  assign inc_press  = press_q[1];
  assign in_set     = (mode_q != RUN);
  assign timeout    = in_set && tick_1hz && (to_cnt_q == TO_W'(TIMEOUT_SECS - 1));

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    sel_pulse = '0;
    case (mode_q)
      SET_HRS: sel_pulse = 3'b001;
      SET_MIN: sel_pulse = 3'b010;
      SET_SEC: sel_pulse = 3'b100;
      default: ;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_DELAY + 1);
  logic            rep_act_q;
  logic [RP_W-1:0] rep_cnt_q;
`endif

  // Priority: timeout, then mode press, then inc press (then auto-repeat).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q   <= RUN;
      inc_q    <= '0;
      to_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
      rep_act_q <= 1'b0;
      rep_cnt_q <= '0;
`endif
    end else begin
      inc_q <= '0;
      if (timeout) begin
        mode_q   <= RUN;
        to_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
`endif
      end else if (mode_press) begin
        mode_q   <= mode_e'(mode_q + 2'd1);
        to_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
`endif
      end else if (inc_press && in_set) begin
        inc_q    <= sel_pulse;
        to_cnt_q <= '0;
`ifdef AUTO_REPEAT_EN
        rep_act_q <= 1'b1;
        rep_cnt_q <= '0;
      end else if (rep_act_q && deb_q[1]) begin
        // Reload keeps subsequent pulses REPEAT_PERIOD apart without a second counter.
        if (rep_cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
          inc_q     <= sel_pulse;
          to_cnt_q  <= '0;
          rep_cnt_q <= RP_W'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
          rep_cnt_q <= rep_cnt_q + 1'b1;
          if (tick_1hz) to_cnt_q <= to_cnt_q + 1'b1;
        end
`endif
      end else begin
`ifdef AUTO_REPEAT_EN
        rep_act_q <= 1'b0;
        rep_cnt_q <= '0;
`endif
        if (in_set && tick_1hz) to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign mode     = mode_q;
  assign run_tick = tick_1hz & (mode_q == RUN);
  assign inc_hour = inc_q[0];
  assign inc_min  = inc_q[1];
  assign inc_sec  = inc_q[2];

endmodule

// File: tb/tb_time_set_controller.sv
// Bench for time_set_controller: directed scenarios plus random button/tick traffic,
// every cycle compared against a behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_time_set_controller;

  localparam int DEB = 64;
  localparam int TO  = 10;
  localparam int RD  = 512;
  localparam int RP  = 128;

  logic       clk = 1'b0;
  logic       reset, mode_btn, inc_btn, tick_1hz;
  logic [1:0] mode;
  logic       run_tick, inc_hour, inc_min, inc_sec;

  time_set_controller #(
    .DEBOUNCE_TICKS(DEB), .TIMEOUT_SECS(TO), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn), .tick_1hz(tick_1hz),
    .mode(mode), .run_tick(run_tick), .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stimulus levels, applied at each falling edge.
  bit rst_v, bm, bi, tk;

  // Behavioural model: button history, debounce run length, press pipeline, set-state rules.
  bit m_s1[2], m_s2[2], m_deb[2], m_p1[2], m_p2[2];
  int m_run[2];
  int m_mode, m_tcnt, m_k;
  bit m_ract;
  bit [2:0] m_inc;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++) begin
      m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_p1[b] = 0; m_p2[b] = 0; m_run[b] = 0;
    end
    m_mode = 0; m_tcnt = 0; m_k = 0; m_ract = 0; m_inc = 0;
  endfunction

  function automatic void model_step(bit raw_m, bit raw_i, bit tick);
    bit raw[2];
    bit rose;
    bit in_set;
    bit [2:0] hit;
    in_set = (m_mode != 0);
    hit    = in_set ? 3'(1 << (m_mode - 1)) : 3'b000;
    m_inc  = 0;
    if (in_set && tick && m_tcnt + 1 == TO) begin
      m_mode = 0; m_tcnt = 0; m_ract = 0;
    end else if (m_p2[0]) begin
      m_mode = (m_mode + 1) % 4; m_tcnt = 0; m_ract = 0;
    end else if (m_p2[1] && in_set) begin
      m_inc = hit; m_tcnt = 0; m_k = 0;
`ifdef AUTO_REPEAT_EN
      m_ract = 1;
`endif
    end else if (m_ract && m_deb[1]) begin
      m_k++;  // cycles since the first pulse of this hold
      if (m_k == RD || (m_k > RD && (m_k - RD) % RP == 0)) begin
        m_inc = hit; m_tcnt = 0;
      end else if (tick) m_tcnt++;
    end else begin
      m_ract = 0;
      if (in_set && tick) m_tcnt++;
    end
    raw[0] = raw_m;
    raw[1] = raw_i;
    for (int b = 0; b < 2; b++) begin
      rose = 0;
      if (m_s2[b] != m_deb[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin
          m_deb[b] = m_s2[b]; m_run[b] = 0; rose = m_deb[b];
        end
      end else m_run[b] = 0;
      m_p2[b] = m_p1[b]; m_p1[b] = rose;
      m_s2[b] = m_s1[b]; m_s1[b] = raw[b];
    end
  endfunction

  int cyc = 0;
  int n_hour, n_min, n_sec, n_rt, first_hour, first_min;

  task automatic cycle();
    @(negedge clk);
    reset = rst_v; mode_btn = bm; inc_btn = bi; tick_1hz = tk;
    #1;
    cyc++;
    if (reset) model_reset();
    check($sformatf("cyc%0d", cyc), {mode, run_tick, inc_sec, inc_min, inc_hour},
          {2'(m_mode), (tick_1hz && m_mode == 0), m_inc});
    if (inc_hour) begin n_hour++; if (first_hour < 0) first_hour = cyc; end
    if (inc_min)  begin n_min++;  if (first_min < 0)  first_min  = cyc; end
    if (inc_sec)  n_sec++;
    if (run_tick) n_rt++;
    @(posedge clk);
    if (!reset) model_step(mode_btn, inc_btn, tick_1hz);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_counts();
    n_hour = 0; n_min = 0; n_sec = 0; n_rt = 0; first_hour = -1; first_min = -1;
  endtask

  task automatic press_mode();
    bm = 1; run(100); bm = 0; run(100);
  endtask

  task automatic tick_pulse();
    tk = 1; run(1); tk = 0; run(19);
  endtask

  int hold_cyc;
  int exp_mode_seq[4] = '{1, 2, 3, 0};

  initial begin
    rst_v = 1; bm = 0; bi = 0; tk = 0;
    model_reset();
    clear_counts();
    run(5);
    check("reset_mode", mode, 0);
    check("reset_inc", {inc_sec, inc_min, inc_hour}, 0);
    rst_v = 0;
    run(5);

    // Mode presses walk RUN -> SET_HRS -> SET_MIN -> SET_SEC -> RUN.
    for (int i = 0; i < 4; i++) begin
      press_mode();
      check($sformatf("t1_mode%0d", i), mode, exp_mode_seq[i]);
    end
    check("t1_no_inc", n_hour + n_min + n_sec, 0);

    // Bouncing inc in SET_HRS, then a stable hold.
    press_mode();
    clear_counts();
    for (int i = 0; i < 6; i++) begin
      bi = (i % 2 == 0); run(10);
    end
    check("t2_no_bounce_pulse", n_hour, 0);
    bi = 1;
    hold_cyc = cyc + 1;
    for (int i = 0; i < 200 && first_hour < 0; i++) run(1);
    check("t2_seen", first_hour >= 0, 1);
    // 2 sync + DEB debounce + 1 edge + 1 output, from the cycle the raw level is driven.
    check("t2_latency", first_hour - hold_cyc, 2 + DEB + 1 + 1);
    run(100);
    check("t2_one_pulse", n_hour, 1);
    bi = 0; run(100);

    // Tick gating.
    press_mode();
    check("t3_mode_min", mode, 2);
    clear_counts();
    repeat (3) tick_pulse();
    check("t3_gated", n_rt, 0);
    press_mode(); press_mode();
    check("t3_mode_run", mode, 0);
    clear_counts();
    repeat (3) tick_pulse();
    check("t3_passed", n_rt, 3);

    // Timeout in SET_SEC, with and without an intervening press.
    repeat (3) press_mode();
    for (int i = 1; i <= 10; i++) begin
      tk = 1; run(1);
      check($sformatf("t4a_tick%0d", i), mode, (i < 10) ? 3 : 0);
      tk = 0; run(19);
    end
    repeat (3) press_mode();
    clear_counts();
    repeat (5) tick_pulse();
    bi = 1; run(100); bi = 0; run(100);
    check("t4b_inc_sec", n_sec, 1);
    for (int i = 6; i <= 15; i++) begin
      tk = 1; run(1);
      check($sformatf("t4b_tick%0d", i), mode, (i < 15) ? 3 : 0);
      tk = 0; run(19);
    end

    // Mode and inc edges in the same cycle: mode wins, no pulse.
    press_mode();
    clear_counts();
    bm = 1; bi = 1; run(100); bm = 0; bi = 0; run(100);
    check("t5_mode", mode, 2);
    check("t5_no_inc", n_hour + n_min + n_sec, 0);
    press_mode(); press_mode();

    // Held inc in SET_MIN: window of 1000 cycles from the first pulse.
    press_mode(); press_mode();
    clear_counts();
    bi = 1;
    for (int i = 0; i < 200 && first_min < 0; i++) run(1);
    check("t6_first", first_min >= 0, 1);
    run(999);
`ifdef AUTO_REPEAT_EN
    check("t6_pulses", n_min, 5);
`else
    check("t6_pulses", n_min, 1);
`endif
    bi = 0; run(200);

    // Reset in the middle of a hold aborts the set.
    bi = 1; run(300);
    rst_v = 1; run(3);
    check("t6_reset_mode", mode, 0);
    clear_counts();
    rst_v = 0; run(700);
    check("t6_after_reset_mode", mode, 0);
    check("t6_after_reset_inc", n_hour + n_min + n_sec, 0);
    bi = 0; run(100);

    // Random button, tick and reset traffic.
    for (int s = 0; s < 80; s++) begin
      int len;
      bm = ($urandom_range(0, 3) == 0);
      bi = ($urandom_range(0, 1) == 1);
      len = $urandom_range(3, 250);
      if ($urandom_range(0, 19) == 0) begin
        rst_v = 1; tk = 0; run(2); rst_v = 0;
      end
      for (int c = 0; c < len; c++) begin
        tk = ($urandom_range(0, 29) == 0);
        run(1);
      end
      tk = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
